// File: rtl/gate_round_timer_if.sv
// Handshake bundle between the gate-control block, the round timer and the board display logic.
interface gate_round_timer_if #(
  parameter int unsigned GATE_COUNT = 9
);
  logic                  timer_en;
  logic [GATE_COUNT-1:0] completed_gate;
  logic                  vga_blankout;
  logic                  restart;
  logic [3:0]            time_tens;
  logic [3:0]            time_ones;
  logic [3:0]            score_tens;
  logic [3:0]            score_ones;
  logic                  running;
  logic                  round_won;
  logic                  time_up;
  logic                  sec_tick;

  modport master (
    output timer_en, completed_gate, vga_blankout, restart,
    input  time_tens, time_ones, score_tens, score_ones,
    input  running, round_won, time_up, sec_tick
  );

  modport slave (
    input  timer_en, completed_gate, vga_blankout, restart,
    output time_tens, time_ones, score_tens, score_ones,
    output running, round_won, time_up, sec_tick
  );
endinterface

// File: rtl/gate_round_timer.sv
// Round countdown with miss penalties, gate-completion scoring and win/timeout detection,
// driving registered BCD digits and state flags for the board display.
module gate_round_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned MISS_PENALTY  = 5,
  parameter int unsigned GATE_COUNT    = 9
) (
  input logic               clk,
  input logic               resetn,
  gate_round_timer_if.slave bus
);

  localparam int unsigned   PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    SEC_LOAD  = 7'(ROUND_SECONDS);
  localparam logic [7:0]    PENALTY   = 8'(MISS_PENALTY);
  localparam logic [6:0]    SCORE_MAX = 7'd99;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_WIN, S_TIMEOUT} state_t;

  function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [7:0] b);
    logic [7:0] wide;
    wide = {1'b0, a};
    return (wide > b) ? 7'(wide - b) : 7'd0;
  endfunction

  function automatic logic [6:0] sat_add_score(input logic [6:0] a, input logic [15:0] b);
    logic [15:0] sum;
    sum = 16'(a) + b;
    return (sum > 16'(SCORE_MAX)) ? SCORE_MAX : sum[6:0];
  endfunction

  function automatic logic [15:0] popcount(input logic [GATE_COUNT-1:0] v);
    logic [15:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(GATE_COUNT); i++) cnt = cnt + 16'(v[i]);
    return cnt;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [6:0]            seconds_q, seconds_d;
  logic [6:0]            score_q, score_d;
  logic                  blank_prev_q, blank_prev_d;
  logic [GATE_COUNT-1:0] gate_prev_q, gate_prev_d;
  logic [3:0]            time_tens_q, time_tens_d, time_ones_q, time_ones_d;
  logic [3:0]            score_tens_q, score_tens_d, score_ones_q, score_ones_d;

  logic        active, tick, miss, win_hit;
  logic [7:0]  dec;
  logic [6:0]  sec_after;
  logic [15:0] new_gates;

  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_PAUSE);
    tick      = (state_q == S_RUN) && (presc_q == PRESC_MAX);
    miss      = active && bus.vga_blankout && !blank_prev_q;
    dec       = (tick ? 8'd1 : 8'd0) + (miss ? PENALTY : 8'd0);
    sec_after = sat_sub(seconds_q, dec);
    new_gates = active ? popcount(bus.completed_gate & ~gate_prev_q) : 16'd0;
    win_hit   = (state_q == S_RUN) && (&bus.completed_gate);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Win outranks timeout when the last decrement and the final gate land together.
  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.timer_en) state_d = S_RUN;
        S_RUN: begin
          if (win_hit)                state_d = S_WIN;
          else if (sec_after == 7'd0) state_d = S_TIMEOUT;
          else if (!bus.timer_en)     state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (sec_after == 7'd0)   state_d = S_TIMEOUT;
          else if (bus.timer_en)   state_d = S_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bus.running   = (state_q == S_RUN);
    bus.round_won = (state_q == S_WIN);
    bus.time_up   = (state_q == S_TIMEOUT);
    bus.sec_tick  = tick;
  end

  // Prescaler holds its phase through PAUSE so a resumed round keeps its second boundary.
  always_comb begin
    presc_d      = presc_q;
    seconds_d    = seconds_q;
    score_d      = score_q;
    blank_prev_d = bus.vga_blankout;
    gate_prev_d  = bus.completed_gate;
    if (bus.restart) begin
      presc_d   = '0;
      seconds_d = SEC_LOAD;
      score_d   = '0;
    end else if (active) begin
      seconds_d = sec_after;
      if (tick)                    presc_d = '0;
      else if (state_q == S_RUN)   presc_d = presc_q + PW'(1);
      score_d = sat_add_score(score_q, new_gates + (win_hit ? 16'(sec_after) : 16'd0));
    end
    time_tens_d  = bcd_tens(seconds_q);
    time_ones_d  = bcd_ones(seconds_q);
    score_tens_d = bcd_tens(score_q);
    score_ones_d = bcd_ones(score_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q      <= '0;
      seconds_q    <= SEC_LOAD;
      score_q      <= '0;
      blank_prev_q <= 1'b0;
      gate_prev_q  <= '0;
      time_tens_q  <= bcd_tens(SEC_LOAD);
      time_ones_q  <= bcd_ones(SEC_LOAD);
      score_tens_q <= 4'd0;
      score_ones_q <= 4'd0;
    end else begin
      presc_q      <= presc_d;
      seconds_q    <= seconds_d;
      score_q      <= score_d;
      blank_prev_q <= blank_prev_d;
      gate_prev_q  <= gate_prev_d;
      time_tens_q  <= time_tens_d;
      time_ones_q  <= time_ones_d;
      score_tens_q <= score_tens_d;
      score_ones_q <= score_ones_d;
    end
  end

  assign bus.time_tens  = time_tens_q;
  assign bus.time_ones  = time_ones_q;
  assign bus.score_tens = score_tens_q;
  assign bus.score_ones = score_ones_q;

endmodule

// File: tb/tb_gate_round_timer.sv
// Bench for gate_round_timer: directed round scenarios plus randomized play, checked every
// cycle against a behavioural game model, with literal expectations pinning key moments.
module tb_gate_round_timer;

  localparam int TPS   = 4;
  localparam int ROUND = 10;
  localparam int PEN   = 5;
  localparam int NG    = 9;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gate_round_timer_if #(.GATE_COUNT(NG)) bus ();

  gate_round_timer #(
    .TICKS_PER_SEC(TPS), .ROUND_SECONDS(ROUND), .MISS_PENALTY(PEN), .GATE_COUNT(NG)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game model: 0 idle, 1 run, 2 pause, 3 win, 4 timeout.
  int m_st, m_sec, m_score, m_phase, m_sec_disp, m_score_disp;
  int n_st, n_sec, n_score, n_phase;
  bit m_bprev, n_tick, n_miss, n_act;
  logic [NG-1:0] m_gprev;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_st = 0; m_sec = ROUND; m_score = 0; m_phase = 0;
      m_sec_disp = ROUND; m_score_disp = 0; m_bprev = 0; m_gprev = '0;
    end else begin
      m_sec_disp   = m_sec;
      m_score_disp = m_score;
      n_act  = (m_st == 1) || (m_st == 2);
      n_tick = (m_st == 1) && (m_phase == TPS - 1);
      n_miss = n_act && bus.vga_blankout && !m_bprev;
      n_st = m_st; n_sec = m_sec; n_score = m_score; n_phase = m_phase;
      if (bus.restart) begin
        n_st = 0; n_sec = ROUND; n_score = 0; n_phase = 0;
      end else if (n_act) begin
        n_sec = m_sec - (n_tick ? 1 : 0) - (n_miss ? PEN : 0);
        if (n_sec < 0) n_sec = 0;
        if (m_st == 1) n_phase = (m_phase + 1) % TPS;
        n_score = m_score + $countones(bus.completed_gate & ~m_gprev);
        if (m_st == 1 && bus.completed_gate == '1) begin
          n_score += n_sec;
          n_st = 3;
        end else if (n_sec == 0)                 n_st = 4;
        else if (m_st == 1 && !bus.timer_en)     n_st = 2;
        else if (m_st == 2 && bus.timer_en)      n_st = 1;
        if (n_score > 99) n_score = 99;
      end else if (m_st == 0 && bus.timer_en) begin
        n_st = 1;
      end
      m_st = n_st; m_sec = n_sec; m_score = n_score; m_phase = n_phase;
      m_bprev = bus.vga_blankout;
      m_gprev = bus.completed_gate;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("time_tens",  32'(bus.time_tens),  32'(m_sec_disp / 10));
      chk("time_ones",  32'(bus.time_ones),  32'(m_sec_disp % 10));
      chk("score_tens", 32'(bus.score_tens), 32'(m_score_disp / 10));
      chk("score_ones", 32'(bus.score_ones), 32'(m_score_disp % 10));
      chk("running",    32'(bus.running),    32'(m_st == 1));
      chk("round_won",  32'(bus.round_won),  32'(m_st == 3));
      chk("time_up",    32'(bus.time_up),    32'(m_st == 4));
      chk("sec_tick",   32'(bus.sec_tick),   32'((m_st == 1) && (m_phase == TPS - 1)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart_pulse();
    bus.restart = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
  endtask

  task automatic lit_time(input string nm, input int tens, input int ones);
    chk({nm, "_tens"}, 32'(bus.time_tens), 32'(tens));
    chk({nm, "_ones"}, 32'(bus.time_ones), 32'(ones));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [NG-1:0] one_bit;
  int r;

  initial begin
    bus.timer_en = 1'b0; bus.completed_gate = '0; bus.vga_blankout = 1'b0; bus.restart = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    lit_time("reset_time", 1, 0);
    chk("reset_running", 32'(bus.running), 32'd0);

    // Full countdown: entry edge, 40 RUN cycles, one more for the display.
    bus.timer_en = 1'b1;
    cyc(1);
    chk("run_entry", 32'(bus.running), 32'd1);
    cyc(41);
    chk("countdown_time_up", 32'(bus.time_up), 32'd1);
    chk("countdown_running", 32'(bus.running), 32'd0);
    lit_time("countdown_time", 0, 0);

    // Restart from timeout, then pause at 7 with the prescaler at phase 3.
    bus.timer_en = 1'b0;
    restart_pulse();
    cyc(1);
    lit_time("restart_time", 1, 0);
    chk("restart_time_up", 32'(bus.time_up), 32'd0);
    bus.timer_en = 1'b1;
    cyc(15);
    bus.timer_en = 1'b0;
    cyc(21);
    lit_time("pause_time", 0, 7);
    chk("pause_running", 32'(bus.running), 32'd0);
    bus.timer_en = 1'b1;
    cyc(1);
    chk("resume_phase_tick", 32'(bus.sec_tick), 32'd1);
    cyc(2);
    lit_time("resume_time", 0, 6);

    // Held blankout at 8 in PAUSE costs one penalty; a second pulse times out.
    restart_pulse();
    cyc(9);
    bus.timer_en = 1'b0;
    cyc(1);
    bus.vga_blankout = 1'b1;
    cyc(10);
    bus.vga_blankout = 1'b0;
    cyc(2);
    lit_time("penalty_time", 0, 3);
    bus.vga_blankout = 1'b1;
    cyc(1);
    chk("penalty_time_up", 32'(bus.time_up), 32'd1);
    bus.vga_blankout = 1'b0;

    // Tick and miss together at 6.
    bus.timer_en = 1'b1;
    restart_pulse();
    cyc(20);
    bus.vga_blankout = 1'b1;
    chk("combo_tick", 32'(bus.sec_tick), 32'd1);
    cyc(1);
    chk("combo_time_up", 32'(bus.time_up), 32'd1);
    bus.vga_blankout = 1'b0;
    cyc(1);
    lit_time("combo_time", 0, 0);

    // Gates completed with 6 s left: 2 + 7 + 6 bonus.
    restart_pulse();
    cyc(17);
    bus.completed_gate = 9'h003;
    cyc(2);
    chk("gates_score_ones", 32'(bus.score_ones), 32'd2);
    bus.completed_gate = 9'h1FF;
    cyc(2);
    chk("win_flag", 32'(bus.round_won), 32'd1);
    chk("win_score_tens", 32'(bus.score_tens), 32'd1);
    chk("win_score_ones", 32'(bus.score_ones), 32'd5);
    for (int i = 0; i < 20; i++) begin
      bus.vga_blankout = i[1];
      bus.timer_en = i[2];
      cyc(1);
    end
    chk("win_frozen_score", 32'(bus.score_ones), 32'd5);
    lit_time("win_frozen_time", 0, 6);

    // Restart mid-RUN, then async reset mid-RUN.
    bus.timer_en = 1'b1; bus.vga_blankout = 1'b0; bus.completed_gate = '0;
    restart_pulse();
    cyc(9);
    restart_pulse();
    cyc(1);
    lit_time("midrun_restart_time", 1, 0);
    cyc(9);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_running", 32'(bus.running), 32'd0);
    chk("async_tick", 32'(bus.sec_tick), 32'd0);
    lit_time("async_time", 1, 0);
    chk("async_score", 32'({bus.score_tens, bus.score_ones}), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      bus.timer_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) bus.vga_blankout = ~bus.vga_blankout;
      r = $urandom_range(0, 59);
      one_bit = 9'h001 << $urandom_range(0, NG - 1);
      if (r == 0)      bus.completed_gate = '1;
      else if (r < 15) bus.completed_gate = bus.completed_gate ^ one_bit;
      else if (r < 18) bus.completed_gate = NG'($urandom);
      bus.restart = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    bus.restart = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
